// File: rtl/interp_pkg.sv
// Shared types and the prototype lowpass for the polyphase interpolator.
// Used by polyphase_interp (optional clamp via POLYPHASE_INTERP_SAT_EN).
package interp_pkg;

  localparam int DATA_W     = 16;
  localparam int COEF_W     = 16;
  localparam int NUM_COEFS  = 32;
  localparam int COEF_IDX_W = $clog2(NUM_COEFS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Hann-windowed sinc, cutoff pi/4, centre between taps 15 and 16.
  // Each of the four phases sums to roughly 2^14.
  localparam logic signed [COEF_W-1:0] COEFS [NUM_COEFS] = '{
    -16'sd1,     -16'sd29,    -16'sd84,    -16'sd72,
     16'sd127,    16'sd485,    16'sd720,    16'sd424,
    -16'sd584,   -16'sd1913,  -16'sd2578,  -16'sd1450,
     16'sd2022,   16'sd7254,   16'sd12572,  16'sd15928,
     16'sd15928,  16'sd12572,  16'sd7254,   16'sd2022,
    -16'sd1450,  -16'sd2578,  -16'sd1913,  -16'sd584,
     16'sd424,    16'sd720,    16'sd485,    16'sd127,
    -16'sd72,    -16'sd84,    -16'sd29,    -16'sd1
  };

  function automatic logic signed [COEF_W-1:0] coef_at(input int idx);
    return COEFS[COEF_IDX_W'(idx)];
  endfunction

endpackage

// File: rtl/interp_shift_sat.sv
// Output scaler: arithmetic right shift of the accumulator, then 16-bit
// narrowing (clamp when POLYPHASE_INTERP_SAT_EN is defined, wrap otherwise).
module interp_shift_sat #(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] sum_in,
  input  logic        [4:0]       shift,
  output logic signed [15:0]      result
);

`ifdef POLYPHASE_INTERP_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = $signed({{(ACC_W-16){1'b0}}, 16'h7fff});
  localparam logic signed [ACC_W-1:0] MIN_V = $signed({{(ACC_W-16){1'b1}}, 16'h8000});

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum_in >>> shift;
    if (shifted > MAX_V) begin
      result = 16'sh7fff;
    end else if (shifted < MIN_V) begin
      result = -16'sh8000;
    end else begin
      result = shifted[15:0];
    end
  end
`else
  always_comb begin
    result = 16'(sum_in >>> shift);
  end
`endif

endmodule

// File: rtl/polyphase_interp.sv
// Polyphase FIR interpolator: one input sample -> L output samples through a
// single time-shared MAC. Define POLYPHASE_INTERP_SAT_EN for output clamping.
module polyphase_interp
  import interp_pkg::*;
#(
  parameter int L     = 4,
  parameter int TAPS  = 32,
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           right_shift,
  input  logic                 single_valid_in,
  input  logic [15:0]          data_in,
  output logic                 in_ready,
  output logic                 valid_out,
  output logic [15:0]          data_out,
  output logic [$clog2(L)-1:0] phase_out,
  output logic                 overrun
);

  localparam int N     = TAPS / L;
  localparam int PH_W  = $clog2(L);
  localparam int TAP_W = (N > 1) ? $clog2(N) : 1;

  // Input handshake: single_valid_in is a one-cycle strobe, taken only on a
  // clock edge where in_ready is high; a strobe seen while in_ready is low is
  // dropped and latches overrun. Outputs have no backpressure: valid_out is a
  // one-cycle pulse that downstream must consume.

  state_e                    state_q, state_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  x_q [N];
  logic signed [DATA_W-1:0]  x_d [N];
  logic signed [DATA_W-1:0]  data_out_q, data_out_d;
  logic [PH_W-1:0]           phase_out_q, phase_out_d;
  logic                      valid_out_q, valid_out_d;
  logic                      overrun_q, overrun_d;

  logic signed [COEF_W-1:0]   coef;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [DATA_W-1:0]   scaled;
  logic                       last_tap;

  // Phase p uses every L-th prototype tap, so the index is just {tap, phase}.
  assign coef     = coef_at(int'({tap_q, phase_q}));
  assign prod     = x_q[tap_q] * coef;
  assign acc_sum  = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign last_tap = (tap_q == TAP_W'(N-1));

  interp_shift_sat #(
    .ACC_W(ACC_W)
  ) u_shift_sat (
    .sum_in(acc_sum),
    .shift (right_shift),
    .result(scaled)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    x_d         = x_q;
    data_out_d  = data_out_q;
    phase_out_d = phase_out_q;
    valid_out_d = 1'b0;
    overrun_d   = overrun_q | (single_valid_in && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (single_valid_in) begin
          x_d[0] = data_in;
          for (int k = 1; k < N; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          phase_d = '0;
          tap_d   = '0;
          state_d = ST_MAC;
        end
      end

      ST_MAC: begin
        acc_d = acc_sum;
        if (last_tap) begin
          data_out_d  = scaled;
          phase_out_d = phase_q;
          valid_out_d = 1'b1;
          state_d     = ST_EMIT;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end

      ST_EMIT: begin
        if (phase_q != PH_W'(L-1)) begin
          phase_d = phase_q + PH_W'(1);
          acc_d   = '0;
          tap_d   = '0;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      phase_out_q <= '0;
      valid_out_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      phase_out_q <= phase_out_d;
      valid_out_q <= valid_out_d;
      overrun_q   <= overrun_d;
      x_q         <= x_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign phase_out = phase_out_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_polyphase_interp.sv
// Bench for polyphase_interp: directed steps with random data, checked against
// a direct-form interpolation model built from the filter definition.
module tb_polyphase_interp;

  localparam int L    = 4;
  localparam int TAPS = 32;
  localparam int N    = TAPS / L;

  logic        clk;
  logic        rst;
  logic [4:0]  right_shift;
  logic        single_valid_in;
  logic [15:0] data_in;
  logic        in_ready;
  logic        valid_out;
  logic [15:0] data_out;
  logic [1:0]  phase_out;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int acc_edge = 0;

  logic [15:0] exp_q[$];
  int          exp_ph_q[$];
  logic [15:0] got_q[$];
  int          got_ph_q[$];
  int          got_edge_q[$];
  int          hist[$];

  int h_ref [TAPS] = '{
       -1,    -29,    -84,    -72,   127,   485,   720,   424,
     -584,  -1913,  -2578,  -1450,  2022,  7254, 12572, 15928,
    15928,  12572,   7254,   2022, -1450, -2578, -1913,  -584,
      424,    720,    485,    127,   -72,   -84,   -29,    -1
  };

  polyphase_interp #(
    .L(L), .TAPS(TAPS), .ACC_W(40)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .right_shift    (right_shift),
    .single_valid_in(single_valid_in),
    .data_in        (data_in),
    .in_ready       (in_ready),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .phase_out      (phase_out),
    .overrun        (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // output collector
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      got_q.push_back(data_out);
      got_ph_q.push_back(int'(phase_out));
      got_edge_q.push_back(edge_cnt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // y_p[n] = sum_k x[n-k] * h[k*L + p], then >>> shift and narrowed to 16 bits
  function automatic logic [15:0] model_out(input int p, input int sh);
    longint acc = 0;
    for (int k = 0; k < N; k++) begin
      int idx = hist.size() - 1 - k;
      if (idx >= 0) acc += longint'(hist[idx]) * longint'(h_ref[k*L + p]);
    end
    acc = acc >>> sh;
`ifdef POLYPHASE_INTERP_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  // driver: called at a negedge; strobes once in_ready is seen
  task automatic send(input int d, input int sh);
    int w = 0;
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", in_ready, 1);
    right_shift     = 5'(sh);
    data_in         = 16'(d);
    single_valid_in = 1'b1;
    @(negedge clk);
    single_valid_in = 1'b0;
    data_in         = 16'($urandom);
    acc_edge        = edge_cnt;
    hist.push_back(d);
    if (hist.size() > N) void'(hist.pop_front());
    for (int p = 0; p < L; p++) begin
      exp_q.push_back(model_out(p, sh));
      exp_ph_q.push_back(p);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (in_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("idle_reached", in_ready, 1);
  endtask

  task automatic flush_queues();
    exp_q.delete();
    exp_ph_q.delete();
    got_q.delete();
    got_ph_q.delete();
    got_edge_q.delete();
  endtask

  // scoreboard: collected pulses against the expected queue
  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
      chk({tag, "_phase"}, got_ph_q.pop_front(), exp_ph_q.pop_front());
    end
    flush_queues();
  endtask

  task automatic impulse_check(input string tag);
    logic [15:0] e;
    send(16384, 14);
    for (int i = 0; i < 7; i++) send(0, 14);
    wait_idle();
    chk({tag, "_count"}, got_q.size(), TAPS);
    for (int i = 0; i < TAPS && i < got_q.size(); i++) begin
      e = h_ref[i][15:0];
      chk({tag, "_coef"}, got_q[i], e);
      chk({tag, "_phase"}, got_ph_q[i], i % L);
    end
    flush_queues();
  endtask

  initial begin
    int t0;
    int lowbad;
    rst             = 1'b1;
    single_valid_in = 1'b0;
    data_in         = '0;
    right_shift     = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_phase_out", phase_out, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // impulse response from a clean delay line
    impulse_check("impulse");

    // pulse timing and back-to-back acceptance
    send(int'($urandom_range(0, 65535)) - 32768, 12);
    t0 = acc_edge;
    lowbad = 0;
    for (int i = 0; i < 36; i++) begin
      if (in_ready !== 1'b0) lowbad++;
      @(negedge clk);
    end
    chk("busy_ready_high_cycles", lowbad, 0);
    chk("ready_cycle", edge_cnt - t0 + 1, L * (N + 1) + 1);
    chk("ready_again", in_ready, 1);
    send(int'($urandom_range(0, 65535)) - 32768, 12);
    chk("back_to_back_taken", in_ready, 0);
    chk("back_to_back_overrun", overrun, 0);
    wait_idle();
    for (int p = 0; p < L; p++) begin
      chk("pulse_cycle", (p < got_edge_q.size()) ? got_edge_q[p] - t0 + 1 : -1, (N + 1) * (p + 1));
    end
    check_stream("timing");

    // overrun: second strobe five cycles after acceptance is dropped
    send(int'($urandom_range(0, 65535)) - 32768, 13);
    repeat (4) @(negedge clk);
    data_in         = 16'd12345;
    single_valid_in = 1'b1;
    @(negedge clk);
    single_valid_in = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_idle();
    check_stream("overrun_pulses");
    chk("overrun_sticky", overrun, 1);
    send(int'($urandom_range(0, 65535)) - 32768, 13);
    wait_idle();
    check_stream("after_drop");
    chk("overrun_still", overrun, 1);

    // DC
    for (int i = 0; i < 10; i++) send(1000, 14);
    wait_idle();
    check_stream("dc");

    // random data, shift and idle gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(10, 16)));
    end
    wait_idle();
    check_stream("random");

    // full-scale input with no scaling
    for (int i = 0; i < 10; i++) send(32767, 0);
    wait_idle();
    check_stream("fullscale");

    // reset during phase 2 MAC
    send(int'($urandom_range(0, 65535)) - 32768, 10);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_overrun", overrun, 0);
    repeat (40) @(negedge clk);
    chk("midrst_pulses", got_q.size(), 2);
    flush_queues();
    hist.delete();
    impulse_check("post_reset_impulse");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/polyphase_interp.md
Name: polyphase_interp

Overview:
- Polyphase FIR interpolator: each accepted input sample yields L output samples at L× rate, using time-multiplexed single-MAC arithmetic.
- Upsampling counterpart of the decimating LPF path, e.g. feeding a DAC/audio-out stage from a low-rate sample stream.
- Input side uses the same single-cycle strobe convention; output side emits one-cycle valid pulses tagged with phase index.

Parameters:
- L, 4, interpolation factor (power of 2, ≥2)
- TAPS, 32, prototype filter length; must be a multiple of L; N = TAPS/L taps per phase
- ACC_W, 40, signed accumulator width (≥ 32 + clog2(N))

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- right_shift  input  5  arithmetic output scale-down, 0..31
- single_valid_in  input  1  one-cycle strobe: data_in valid
- data_in  input  16  signed input sample
- in_ready  output  1  high only in IDLE; strobe accepted only when high
- valid_out  output  1  one-cycle pulse per output sample
- data_out  output  16  signed output sample, held between pulses
- phase_out  output  clog2(L)  phase index of current data_out, 0..L-1
- overrun  output  1  sticky: strobe arrived while in_ready low

Behaviour:
- Reset (async, any state): in_ready=1, valid_out=0, data_out=0, phase_out=0, overrun=0; delay line (N×16) zeroed; state=IDLE; in-flight outputs abandoned, no further pulses.
- States: IDLE, MAC, EMIT.
- IDLE: on single_valid_in, shift data_in into delay line x[0] (x[k] <= x[k-1]), clear accumulator, phase=0, tap=0, go to MAC.
- MAC: N cycles; accumulator += x[tap] * h[tap*L + phase] (16×16 signed → 32-bit, sign-extended to ACC_W). On the last MAC edge, data_out <= f(final sum), phase_out <= phase, valid_out <= 1; go to EMIT.
- EMIT: valid_out high for this one cycle only. If phase < L-1: phase++, clear accumulator, tap=0, go to MAC. Otherwise go to IDLE.
- Timing, with acceptance edge = cycle 0: valid_out high in cycles (N+1)(p+1) for p=0..L-1 (defaults: 9, 18, 27, 36). in_ready high again at cycle L(N+1)+1 (default 37). Minimum input period L(N+1)+1 = 37 cycles.
- Strobe accepted on the same cycle in_ready returns high: legal, no gap.
- Strobe while in_ready=0: sample dropped, delay line untouched, overrun <= 1 (cleared only by rst).
- f(sum): sum >>> right_shift (arithmetic), then narrowed to 16 bits per the optional feature. right_shift is sampled on the last MAC edge.
- No output backpressure; downstream must accept every pulse.

Optional Feature:
- Macro POLYPHASE_INTERP_SAT_EN.
- Defined: shifted value clamps to [-32768, 32767].
- Undefined: low 16 bits kept (two's-complement wrap).

Decomposition:
- Package interp_pkg holds: DATA_W=16, COEF_W=16; state enum typedef; default 32-entry signed coefficient array (symmetric lowpass, cutoff π/L, DC gain per phase ≈ 2^14).
- Coefficient access: module indexes the package array with a tap*L+phase index.
- Sub-module interp_shift_sat (combinational): ACC_W sum + right_shift → 16-bit result; contains the POLYPHASE_INTERP_SAT_EN ifdef.

Test Plan:
- Impulse: data_in=16384, then 7 zero samples, right_shift=14 → 32 valid_out pulses; data_out equals h[0..31] in order; phase_out cycles 0,1,2,3.
- Timing: single strobe at cycle 0 → valid_out exactly at cycles 9, 18, 27, 36; in_ready low cycles 1–36, high at 37; second strobe at 37 accepted with overrun=0.
- Overrun: strobes at cycle 0 and cycle 5 → second dropped, overrun=1 and stays 1, exactly 4 output pulses; next accepted sample behaves as if the dropped one never arrived.
- DC: data_in=1000 for 10 samples, right_shift=14 → after 8th input each phase p gives 1000·Σh[kL+p]>>14 (±1 of reference model).
- Saturation: data_in=32767 steady, right_shift=0 → SAT_EN: data_out=32767 for positive-sum phases; without: low 16 bits of the exact sum, matching model.
- Reset mid-op: rst asserted during MAC cycle 3 of phase 2 → valid_out=0 immediately, in_ready=1 and overrun=0 after release; subsequent impulse reproduces h[0..31] exactly (delay line cleared).
